// File: rtl/boss_proj_scheduler_if.sv
// boss_proj_scheduler_if
// Groups the projectile scheduler's request, collision, read-port and status
// signals into one bundle.
//   master modport: drives tick, spawn request, geometry, rd_idx; observes status.
//   slave modport : the scheduler side (inputs/outputs mirrored).
// Signals:
//   pulse_stepCycle       movement tick
//   spawn_req/spawn_mask  spawn event and per-request qualifiers
//   req0X..req4X/req0Y..req4Y  spawn coordinates
//   projW/projH, plyX/plyY/plyW/plyH  collision geometry
//   rd_idx -> rd_x/rd_y/rd_valid      slot read port (1-cycle latency)
//   busy, spawn_drop, playerHit, active_count  status
interface boss_proj_scheduler_if #(
  parameter int NSLOT = 8
);
  localparam int IW = $clog2(NSLOT);

  logic          pulse_stepCycle;
  logic          spawn_req;
  logic [4:0]    spawn_mask;
  logic [9:0]    req0X, req1X, req2X, req3X, req4X;
  logic [8:0]    req0Y, req1Y, req2Y, req3Y, req4Y;
  logic [9:0]    projW;
  logic [8:0]    projH;
  logic [9:0]    plyX;
  logic [8:0]    plyY;
  logic [9:0]    plyW;
  logic [8:0]    plyH;
  logic [IW-1:0] rd_idx;
  logic [9:0]    rd_x;
  logic [8:0]    rd_y;
  logic          rd_valid;
  logic          busy;
  logic          spawn_drop;
  logic          playerHit;
  logic [IW:0]   active_count;

  modport master (
    output pulse_stepCycle, spawn_req, spawn_mask,
    output req0X, req1X, req2X, req3X, req4X,
    output req0Y, req1Y, req2Y, req3Y, req4Y,
    output projW, projH, plyX, plyY, plyW, plyH, rd_idx,
    input  rd_x, rd_y, rd_valid, busy, spawn_drop, playerHit, active_count
  );

  modport slave (
    input  pulse_stepCycle, spawn_req, spawn_mask,
    input  req0X, req1X, req2X, req3X, req4X,
    input  req0Y, req1Y, req2Y, req3Y, req4Y,
    input  projW, projH, plyX, plyY, plyW, plyH, rd_idx,
    output rd_x, rd_y, rd_valid, busy, spawn_drop, playerHit, active_count
  );
endinterface

// File: rtl/boss_proj_scheduler.sv
// boss_proj_scheduler
// Holds NSLOT falling projectiles. A spawn event latches up to five requests
// and the ALLOC state places one masked request per cycle into the
// lowest-index free slot. Each movement tick advances every live projectile by
// SPEED and retires those reaching SCREEN_H.
// Optional feature: define BOSS_PROJ_COLLIDE_EN to clear projectiles that
// overlap the player box on a tick and pulse playerHit.
// Ports:
//   clk_master  clock (rising edge)
//   rst         synchronous active-high reset
//   bus         boss_proj_scheduler_if.slave (tick, spawn, geometry, read port,
//               busy, spawn_drop, playerHit, active_count)
// spawn_drop and playerHit are registered: they pulse in the cycle after the
// event that caused them.
module boss_proj_scheduler #(
  parameter int NSLOT    = 8,
  parameter int SPEED    = 4,
  parameter int SCREEN_H = 480
) (
  input logic clk_master,
  input logic rst,
  boss_proj_scheduler_if.slave bus
);
  localparam int IW = $clog2(NSLOT);
  localparam int CW = IW + 1;

  typedef enum logic {IDLE, ALLOC} state_t;

  state_t           state;
  logic [NSLOT-1:0] slot_valid;
  logic [9:0]       slot_x [NSLOT];
  logic [8:0]       slot_y [NSLOT];

  logic [4:0]       lat_mask;
  logic [9:0]       lat_x [5];
  logic [8:0]       lat_y [5];

  logic [9:0]       req_x [5];
  logic [8:0]       req_y [5];
  logic [2:0]       cur_idx;
  logic [4:0]       cur_onehot;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic [NSLOT-1:0] hit;

  function automatic logic [9:0] step_y(input logic [8:0] y);
    return {1'b0, y} + 10'(SPEED);
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [NSLOT-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NSLOT; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
    req_x[0] = bus.req0X; req_x[1] = bus.req1X; req_x[2] = bus.req2X;
    req_x[3] = bus.req3X; req_x[4] = bus.req4X;
    req_y[0] = bus.req0Y; req_y[1] = bus.req1Y; req_y[2] = bus.req2Y;
    req_y[3] = bus.req3Y; req_y[4] = bus.req4Y;
  end

  // Lowest pending request is the one served this ALLOC cycle.
  always_comb begin
    cur_idx = 3'd0;
    for (int i = 4; i >= 0; i--) if (lat_mask[i]) cur_idx = 3'(i);
    cur_onehot = 5'b00001 << cur_idx;
  end

  // Free-slot search uses the registered valid bits, so a slot retired by a
  // tick in this same cycle is only offered from the next cycle on.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

`ifdef BOSS_PROJ_COLLIDE_EN
  // Pre-move box overlap, strict on every edge.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      hit[i] = slot_valid[i]
               && ({1'b0, slot_x[i]} < {1'b0, bus.plyX} + {1'b0, bus.plyW})
               && ({1'b0, slot_x[i]} + {1'b0, bus.projW} > {1'b0, bus.plyX})
               && ({1'b0, slot_y[i]} < {1'b0, bus.plyY} + {1'b0, bus.plyH})
               && ({1'b0, slot_y[i]} + {1'b0, bus.projH} > {1'b0, bus.plyY});
    end
  end
`else
  assign hit = '0;
  logic unused_geom;
  assign unused_geom = ^{bus.projW, bus.projH, bus.plyX, bus.plyY, bus.plyW, bus.plyH};
`endif

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state            <= IDLE;
      slot_valid       <= '0;
      lat_mask         <= '0;
      bus.busy         <= 1'b0;
      bus.spawn_drop   <= 1'b0;
      bus.playerHit    <= 1'b0;
      bus.active_count <= '0;
      bus.rd_x         <= '0;
      bus.rd_y         <= '0;
      bus.rd_valid     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        lat_x[r] <= '0;
        lat_y[r] <= '0;
      end
    end else begin
      bus.spawn_drop <= 1'b0;
      bus.playerHit  <= 1'b0;

      // Stage: movement / retirement / collision on tick
      if (bus.pulse_stepCycle) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (slot_valid[i]) begin
            if (hit[i] || (step_y(slot_y[i]) >= 10'(SCREEN_H))) slot_valid[i] <= 1'b0;
            else slot_y[i] <= step_y(slot_y[i])[8:0];
          end
        end
        bus.playerHit <= |hit;
      end

      // Stage: allocation FSM (its slot write lands after the tick update,
      // so a freshly spawned slot keeps its spawn Y)
      case (state)
        IDLE: begin
          if (bus.spawn_req && (bus.spawn_mask != 5'd0)) begin
            state    <= ALLOC;
            bus.busy <= 1'b1;
            lat_mask <= bus.spawn_mask;
            for (int r = 0; r < 5; r++) begin
              lat_x[r] <= req_x[r];
              lat_y[r] <= req_y[r];
            end
          end
        end
        ALLOC: begin
          if (bus.spawn_req) bus.spawn_drop <= 1'b1;
          if (free_found) begin
            slot_valid[free_idx] <= 1'b1;
            slot_x[free_idx]     <= lat_x[cur_idx];
            slot_y[free_idx]     <= lat_y[cur_idx];
          end else begin
            bus.spawn_drop <= 1'b1;
          end
          lat_mask <= lat_mask & ~cur_onehot;
          if ((lat_mask & ~cur_onehot) == 5'd0) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase

      // Stage: registered status and read port
      bus.active_count <= popcnt(slot_valid);
      bus.rd_x         <= slot_x[bus.rd_idx];
      bus.rd_y         <= slot_y[bus.rd_idx];
      bus.rd_valid     <= slot_valid[bus.rd_idx];
    end
  end
endmodule
